// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per
// cycle over 32 iterations, result and one-cycle write pulse on entry to DONE.
module muldiv_unit (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_kill,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    input  logic [4:0]  i_rd_addr,
    output logic        o_busy,
    output logic        o_rd_wren,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd_data
);

    localparam int DATA_W = 32;
    localparam int STAGES = 32;
    localparam int CNT_W  = $clog2(STAGES);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Magnitude of a signed value; 0x80000000 maps onto itself, which is its
    // correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v);
        logic signed [DATA_W-1:0] n;
        n = -v;
        return (v < 0) ? DATA_W'(n) : DATA_W'(v);
    endfunction

    function automatic logic [2*DATA_W-1:0] negate64(input logic [2*DATA_W-1:0] v);
        return ~v + 64'd1;
    endfunction

    function automatic logic [DATA_W-1:0] negate32(input logic [DATA_W-1:0] v);
        return ~v + 32'd1;
    endfunction

    state_t             state, state_nx;
    logic [CNT_W-1:0]   count;
    logic               launch, step, finish;

    // Captured operation context
    logic [2:0]         op_p0;
    logic [4:0]         rd_p0;
    logic               neg_p0;
    logic               dz_p0;
    logic               ovf_p0;
    logic [DATA_W-1:0]  opnd_p0;
    logic [DATA_W-1:0]  rs1_raw_p0;

    // Iteration registers: acc is the product high word / partial remainder,
    // lo is the multiplier/product low word or the dividend/quotient.
    logic [DATA_W-1:0]  acc_p1, lo_p1;

    logic signed [DATA_W-1:0] rs1_s, rs2_s;
    logic               rs1_signed, rs2_signed, n1, n2, is_div_in;
    logic               neg_in, dz_in, ovf_in;
    logic [DATA_W-1:0]  a_mag, b_mag;

    logic               is_div;
    logic [DATA_W:0]    mul_sum, div_shift;
    logic               div_ge;
    logic [DATA_W-1:0]  div_diff;
    logic [DATA_W-1:0]  acc_nx, lo_nx;
    logic [2*DATA_W-1:0] prod, prod_s;
    logic [DATA_W-1:0]  quot_s, rem_s, result;

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nx;
            if (launch)
                count <= '0;
            else if (step)
                count <= count + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        launch   = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nx = CALC;
                    launch   = 1'b1;
                end
            end
            CALC: begin
                step = 1'b1;
                if (count == CNT_W'(STAGES - 1)) begin
                    state_nx = DONE;
                    finish   = 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // Kill wins over everything, including a same-cycle start
        if (i_kill) begin
            state_nx = IDLE;
            launch   = 1'b0;
            step     = 1'b0;
            finish   = 1'b0;
        end
    end

    assign o_busy    = (state != IDLE);
    assign o_rd_wren = (state == DONE);

    // ---------------- p0: operand capture ----------------
    always_comb begin
        rs1_s      = i_rs1_data;
        rs2_s      = i_rs2_data;
        rs1_signed = (i_funct3 == F_MULH) || (i_funct3 == F_MULHSU) ||
                     (i_funct3 == F_DIV)  || (i_funct3 == F_REM);
        rs2_signed = (i_funct3 == F_MULH) || (i_funct3 == F_DIV) || (i_funct3 == F_REM);
        n1         = rs1_signed && (rs1_s < 0);
        n2         = rs2_signed && (rs2_s < 0);
        a_mag      = rs1_signed ? mag(rs1_s) : i_rs1_data;
        b_mag      = rs2_signed ? mag(rs2_s) : i_rs2_data;
        is_div_in  = i_funct3[2];
        neg_in     = 1'b0;
        case (i_funct3)
            F_MULH, F_DIV:   neg_in = n1 ^ n2;
            F_MULHSU, F_REM: neg_in = n1;
            default:         neg_in = 1'b0;
        endcase
        dz_in  = (i_rs2_data == '0);
        ovf_in = ((i_funct3 == F_DIV) || (i_funct3 == F_REM)) &&
                 (i_rs1_data == 32'h8000_0000) && (i_rs2_data == 32'hFFFF_FFFF);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            op_p0  <= F_MUL;
            rd_p0  <= '0;
            neg_p0 <= 1'b0;
            dz_p0  <= 1'b0;
            ovf_p0 <= 1'b0;
        end else if (launch) begin
            op_p0  <= i_funct3;
            rd_p0  <= i_rd_addr;
            neg_p0 <= neg_in;
            dz_p0  <= dz_in;
            ovf_p0 <= ovf_in;
        end
    end

    always_ff @(posedge i_clk) begin
        if (launch) begin
            opnd_p0    <= is_div_in ? b_mag : a_mag;
            rs1_raw_p0 <= i_rs1_data;
        end
    end

    // ---------------- p1: iteration ----------------
    always_comb begin
        is_div    = op_p0[2];
        mul_sum   = {1'b0, acc_p1} + {1'b0, (lo_p1[0] ? opnd_p0 : '0)};
        div_shift = {acc_p1, lo_p1[DATA_W-1]};
        div_ge    = (div_shift >= {1'b0, opnd_p0});
        div_diff  = div_shift[DATA_W-1:0] - opnd_p0;
        if (is_div) begin
            acc_nx = div_ge ? div_diff : div_shift[DATA_W-1:0];
            lo_nx  = {lo_p1[DATA_W-2:0], div_ge};
        end else begin
            acc_nx = mul_sum[DATA_W:1];
            lo_nx  = {mul_sum[0], lo_p1[DATA_W-1:1]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (launch) begin
            acc_p1 <= '0;
            lo_p1  <= is_div_in ? a_mag : b_mag;
        end else if (step) begin
            acc_p1 <= acc_nx;
            lo_p1  <= lo_nx;
        end
    end

    // ---------------- p2: sign correction and result ----------------
    always_comb begin
        prod   = {acc_nx, lo_nx};
        prod_s = neg_p0 ? negate64(prod) : prod;
        quot_s = neg_p0 ? negate32(lo_nx) : lo_nx;
        rem_s  = neg_p0 ? negate32(acc_nx) : acc_nx;
        case (op_p0)
            F_MUL:                      result = prod_s[DATA_W-1:0];
            F_MULH, F_MULHSU, F_MULHU:  result = prod_s[2*DATA_W-1:DATA_W];
            F_DIV, F_DIVU:              result = dz_p0 ? 32'hFFFF_FFFF :
                                                 ovf_p0 ? 32'h8000_0000 : quot_s;
            F_REM, F_REMU:              result = dz_p0 ? rs1_raw_p0 :
                                                 ovf_p0 ? 32'h0000_0000 : rem_s;
            default:                    result = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_rd_data <= '0;
            o_rd_addr <= '0;
        end else if (finish) begin
            o_rd_data <= result;
            o_rd_addr <= rd_p0;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic results, latency, kill, back-to-back
// launch and asynchronous reset behaviour.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd_in;
    logic        busy;
    logic        wren;
    logic [4:0]  rd_out;
    logic [31:0] data_out;

    int errors = 0;
    int checks = 0;

    muldiv_unit dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_start    (start),
        .i_kill     (kill),
        .i_funct3   (funct3),
        .i_rs1_data (rs1),
        .i_rs2_data (rs2),
        .i_rd_addr  (rd_in),
        .o_busy     (busy),
        .o_rd_wren  (wren),
        .o_rd_addr  (rd_out),
        .o_rd_data  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation and watch 40 negedges after the launch edge.
    // lat is the negedge index of the first write pulse (33 = cycle after E32).
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] data, output logic [4:0] addr,
                          output int lat, output int pulses, output logic busy_e0,
                          output logic busy_e33);
        @(negedge clk);
        start = 1'b1; funct3 = f3; rs1 = a; rs2 = b; rd_in = rd;
        @(posedge clk);
        #1;
        start = 1'b0; rs1 = $urandom; rs2 = $urandom; rd_in = 5'($urandom);
        lat = 0; pulses = 0; data = '0; addr = '0; busy_e0 = 1'b0; busy_e33 = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1)  busy_e0  = busy;
            if (i == 34) busy_e33 = busy;
            if (wren) begin
                pulses++;
                if (lat == 0) begin
                    lat  = i;
                    data = data_out;
                    addr = rd_out;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0; rd_in = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b expected 0", wren); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", data_out); end
        checks++; if (rd_out !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", rd_out); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul_signed;
        logic [31:0] d; logic [4:0] ad; int lat, np; logic b0, b33;
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, d, ad, lat, np, b0, b33);
        checks++; if (d !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_data: got %h expected ffffffeb", d); end
        checks++; if (ad !== 5'd5) begin errors++; $display("FAIL mul_addr: got %0d expected 5", ad); end
        checks++; if (lat != 33) begin errors++; $display("FAIL mul_latency: got %0d expected 33", lat); end
        checks++; if (np != 1) begin errors++; $display("FAIL mul_pulses: got %0d expected 1", np); end
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL busy_rise: got %b expected 1", b0); end
        checks++; if (b33 !== 1'b0) begin errors++; $display("FAIL busy_fall: got %b expected 0", b33); end
        checks++; if (data_out !== 32'hFFFF_FFEB) begin errors++; $display("FAIL data_hold: got %h expected ffffffeb", data_out); end
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, d, ad, lat, np, b0, b33);
        checks++; if (d !== 32'h4000_0000) begin errors++; $display("FAIL mulh_data: got %h expected 40000000", d); end
    endtask

    task automatic test_mul_unsigned;
        logic [31:0] d; logic [4:0] ad; int lat, np; logic b0, b33;
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, d, ad, lat, np, b0, b33);
        checks++; if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu_data: got %h expected fffffffe", d); end
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, d, ad, lat, np, b0, b33);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu_data: got %h expected ffffffff", d); end
    endtask

    task automatic test_div;
        logic [31:0] d; logic [4:0] ad; int lat, np; logic b0, b33;
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10, d, ad, lat, np, b0, b33);
        checks++; if (d !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_data: got %h expected fffffffd", d); end
        checks++; if (lat != 33) begin errors++; $display("FAIL div_latency: got %0d expected 33", lat); end
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11, d, ad, lat, np, b0, b33);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_data: got %h expected ffffffff", d); end
        run_op(3'b101, 32'd100, 32'd7, 5'd12, d, ad, lat, np, b0, b33);
        checks++; if (d !== 32'd14) begin errors++; $display("FAIL divu_data: got %h expected 0000000e", d); end
        run_op(3'b111, 32'd100, 32'd7, 5'd0, d, ad, lat, np, b0, b33);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL remu_data: got %h expected 00000002", d); end
        checks++; if (np != 1) begin errors++; $display("FAIL x0_wren: got %0d pulses expected 1", np); end
    endtask

    task automatic test_div_corner;
        logic [31:0] d; logic [4:0] ad; int lat, np; logic b0, b33;
        run_op(3'b100, 32'h0000_1234, 32'd0, 5'd13, d, ad, lat, np, b0, b33);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_data: got %h expected ffffffff", d); end
        checks++; if (lat != 33) begin errors++; $display("FAIL div0_latency: got %0d expected 33", lat); end
        run_op(3'b111, 32'h0000_1234, 32'd0, 5'd14, d, ad, lat, np, b0, b33);
        checks++; if (d !== 32'h0000_1234) begin errors++; $display("FAIL remu0_data: got %h expected 00001234", d); end
        run_op(3'b110, 32'hFFFF_FF00, 32'd0, 5'd14, d, ad, lat, np, b0, b33);
        checks++; if (d !== 32'hFFFF_FF00) begin errors++; $display("FAIL rem0_data: got %h expected ffffff00", d); end
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, d, ad, lat, np, b0, b33);
        checks++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL divovf_data: got %h expected 80000000", d); end
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, d, ad, lat, np, b0, b33);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL removf_data: got %h expected 00000000", d); end
    endtask

    task automatic test_kill;
        int np;
        // Last result is REM overflow: data 0, addr 16
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7; rd_in = 5'd20;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL kill_busy: got %b expected 0", busy); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL kill_data: got %h expected 00000000", data_out); end
        checks++; if (rd_out !== 5'd16) begin errors++; $display("FAIL kill_addr: got %0d expected 16", rd_out); end
        np = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wren) np++;
        end
        checks++; if (np != 0) begin errors++; $display("FAIL kill_wren: got %0d pulses expected 0", np); end
    endtask

    task automatic test_start_kill;
        int np, nb;
        @(negedge clk);
        start = 1'b1; kill = 1'b1; funct3 = 3'b000; rs1 = 32'd9; rs2 = 32'd9; rd_in = 5'd21;
        @(posedge clk);
        #1 start = 1'b0; kill = 1'b0;
        np = 0; nb = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wren) np++;
            if (busy) nb++;
        end
        checks++; if (nb != 0) begin errors++; $display("FAIL startkill_busy: got %0d busy cycles expected 0", nb); end
        checks++; if (np != 0) begin errors++; $display("FAIL startkill_wren: got %0d pulses expected 0", np); end
    endtask

    task automatic test_back_to_back;
        int first, second, np;
        logic [31:0] d1, d2;
        logic b34, b35;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd5; rd_in = 5'd22;
        @(posedge clk);
        #1 rs1 = 32'd6;
        first = 0; second = 0; np = 0; d1 = '0; d2 = '0; b34 = 1'b1; b35 = 1'b0;
        for (int i = 1; i <= 75; i++) begin
            @(negedge clk);
            if (i == 34) b34 = busy;
            if (i == 35) begin b35 = busy; start = 1'b0; end
            if (wren) begin
                np++;
                if (first == 0) begin first = i; d1 = data_out; end
                else if (second == 0) begin second = i; d2 = data_out; end
            end
        end
        checks++; if (first != 33) begin errors++; $display("FAIL b2b_first: got %0d expected 33", first); end
        checks++; if (d1 !== 32'd15) begin errors++; $display("FAIL b2b_data1: got %h expected 0000000f", d1); end
        checks++; if (b34 !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got %b expected 0", b34); end
        checks++; if (b35 !== 1'b1) begin errors++; $display("FAIL b2b_relaunch: got %b expected 1", b35); end
        checks++; if (second != 67) begin errors++; $display("FAIL b2b_second: got %0d expected 67", second); end
        checks++; if (d2 !== 32'd30) begin errors++; $display("FAIL b2b_data2: got %h expected 0000001e", d2); end
        checks++; if (np != 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", np); end
    endtask

    task automatic test_reset_mid_calc;
        logic [31:0] d; logic [4:0] ad; int lat, np; logic b0, b33;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b001; rs1 = 32'h1234_5678; rs2 = 32'h0FED_CBA9; rd_in = 5'd25;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (wren !== 1'b0) begin errors++; $display("FAIL rstmid_wren: got %b expected 0", wren); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL rstmid_data: got %h expected 00000000", data_out); end
        checks++; if (rd_out !== 5'd0) begin errors++; $display("FAIL rstmid_addr: got %0d expected 0", rd_out); end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'b000, 32'd3, 32'd5, 5'd7, d, ad, lat, np, b0, b33);
        checks++; if (d !== 32'd15) begin errors++; $display("FAIL postrst_data: got %h expected 0000000f", d); end
        checks++; if (ad !== 5'd7) begin errors++; $display("FAIL postrst_addr: got %0d expected 7", ad); end
        checks++; if (np != 1) begin errors++; $display("FAIL postrst_pulses: got %0d expected 1", np); end
    endtask

    initial begin
        test_reset();
        test_mul_signed();
        test_mul_unsigned();
        test_div();
        test_div_corner();
        test_kill();
        test_start_kill();
        test_back_to_back();
        test_reset_mid_calc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
